// File: rtl/qm_defs.sv
// Shared fetch-path definitions: reset PC, instruction width, FIFO entry layout.
package qm_defs;

  localparam logic [31:0] QM_RESET_PC = 32'h8000_0000;
  localparam int          QM_INSN_W   = 32;

  typedef struct packed {
    logic [31:0]          pc;
    logic [QM_INSN_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] qm_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/qm_fetch_fifo.sv
// Synchronous {pc, instr} FIFO between fetch and decode, with a flush that
// discards every queued entry in one cycle.
module qm_fetch_fifo
  import qm_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [31:0]          push_pc,
  input  logic [QM_INSN_W-1:0] push_instr,
  input  logic                 pop_ready,
  output logic                 out_valid,
  output logic [31:0]          head_pc,
  output logic [QM_INSN_W-1:0] head_instr,
  output logic                 full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;
  fetch_entry_t     mem [DEPTH];

  assign out_valid  = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign pop        = out_valid && pop_ready;
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  // Caller only pushes when not full, so the count never exceeds DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

endmodule

// File: rtl/qm_fetch.sv
// Instruction-fetch stage: owns the PC, drives the icache, and queues fetched
// words toward decode; redirects arriving mid-fill are parked until the fill ends.
module qm_fetch
  import qm_defs::*;
#(
  parameter logic [31:0] RESET_PC  = QM_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          icache_address,
  output logic                 icache_enable,
  input  logic                 icache_hit,
  input  logic                 icache_stall,
  input  logic [QM_INSN_W-1:0] icache_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [QM_INSN_W-1:0] out_instr
);

  logic [31:0]          pc_q;
  logic [31:0]          pend_pc_q;
  logic                 pend_q;
  logic                 fifo_full;
  logic                 can_fetch;
  logic                 fire;
  logic                 head_valid;
  logic [31:0]          head_pc;
  logic [QM_INSN_W-1:0] head_instr;
  logic [31:0]          redirect_tgt;

  assign redirect_tgt   = qm_align(redirect_pc);
  assign can_fetch      = !fifo_full && !pend_q;
  // Enable stays up for the whole fill: the icache FSM only advances while enabled.
  assign icache_enable  = !reset && (icache_stall || can_fetch);
  assign icache_address = pc_q;
  assign fire           = icache_enable && icache_hit && !icache_stall
                          && can_fetch && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
    end else if (redirect_valid) begin
      if (icache_stall) begin
        pend_q <= 1'b1;
      end else begin
        pc_q   <= redirect_tgt;
        pend_q <= 1'b0;
      end
    end else if (pend_q && !icache_stall) begin
      // Fill just finished for the old line; its word is dropped.
      pc_q   <= pend_pc_q;
      pend_q <= 1'b0;
    end else if (fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (redirect_valid && icache_stall) pend_pc_q <= redirect_tgt;
  end

  qm_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fire),
    .push_pc    (pc_q),
    .push_instr (icache_data),
    .pop_ready  (out_ready),
    .out_valid  (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .full       (fifo_full)
  );

  assign out_valid = head_valid;
  assign out_pc    = head_valid ? head_pc : '0;
  assign out_instr = head_valid ? head_instr : '0;

endmodule

// File: tb/tb_qm_fetch.sv
// Bench for qm_fetch: behavioural icache with injectable misses, a stream-level
// scoreboard of expected PCs, directed scenarios and a randomized soak.
module tb_qm_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_address;
  logic        icache_enable;
  logic        icache_hit;
  logic        icache_stall;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [31:0] exp_pc;

  // icache model state
  logic [3:0]  fill_cnt = '0;
  int          arm_seq  = 0;
  int          done_seq = 0;
  logic [31:0] miss_addr = '0;
  int          miss_lat  = 1;
  logic        is_miss;

  always #5 clk = ~clk;

  qm_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .icache_address (icache_address),
    .icache_enable  (icache_enable),
    .icache_hit     (icache_hit),
    .icache_stall   (icache_stall),
    .icache_data    (icache_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // Cached RAM window is 0x8xxxxxxx; anything else reads back as 0 (nop).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:28] == 4'h8) return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    return 32'h0;
  endfunction

  assign is_miss      = (arm_seq != done_seq) && (icache_address == miss_addr);
  assign icache_stall = (fill_cnt != 4'd0);
  assign icache_hit   = icache_enable && (fill_cnt == 4'd0) && !is_miss;
  assign icache_data  = icache_hit ? mem_word(icache_address) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (icache_enable) begin
      if (fill_cnt != 4'd0) begin
        fill_cnt <= fill_cnt - 4'd1;
      end else if (is_miss) begin
        fill_cnt <= 4'(miss_lat);
        done_seq <= arm_seq;
      end
    end
  end

  // Enable must never drop while a fill is in progress.
  always @(negedge clk) begin
    #2;
    if (!reset && icache_stall) begin
      checks++;
      assert (icache_enable === 1'b1) else begin
        errors++;
        $display("FAIL enable_during_fill: observed %b expected 1", icache_enable);
        $error("enable dropped during fill");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at a negedge with inputs already driven; scores the pop (if any)
  // of the coming edge, then advances to the next negedge.
  task automatic tick();
    #1;
    if (reset) begin
      exp_pc = 32'h8000_0000;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_pc", out_pc, exp_pc);
        check("sb_instr", out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm_miss(input int lat);
    miss_addr = icache_address;
    miss_lat  = lat;
    arm_seq++;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = 32'h8000_0000;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_enable", 32'(icache_enable), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);

    // Straight-line fetch, all hits, decode always ready
    reset = 1'b0;
    check("first_addr", icache_address, 32'h8000_0000);
    tick();
    check("seq0_pc", out_pc, 32'h8000_0000);
    check("seq0_instr", out_instr, mem_word(32'h8000_0000));
    tick();
    check("seq1_pc", out_pc, 32'h8000_0004);
    tick();
    check("seq2_pc", out_pc, 32'h8000_0008);

    // Backpressure from a fresh reset: FIFO fills to 2, fetch stops
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    repeat (5) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head", out_pc, 32'h8000_0000);
    check("bp_enable", 32'(icache_enable), 32'd0);
    check("bp_addr", icache_address, 32'h8000_0008);
    out_ready = 1'b1;
    tick();
    check("bp_pop1", out_pc, 32'h8000_0004);
    tick();
    check("bp_pop2", out_pc, 32'h8000_0008);

    // Six-cycle miss at 0x80000010
    miss_addr = 32'h8000_0010;
    miss_lat  = 6;
    arm_seq++;
    n = 0;
    while (!icache_stall && n < 10) begin tick(); n++; end
    check("miss_started", 32'(icache_stall), 32'd1);
    n = 0;
    while (icache_stall && n < 20) begin
      check("miss_addr_held", icache_address, 32'h8000_0010);
      tick();
      n++;
    end
    check("miss_stall_cycles", 32'(n), 32'd6);
    check("miss_no_push", 32'(out_valid), 32'd0);
    tick();
    check("miss_entry", out_pc, 32'h8000_0010);

    // Redirect during a hit, unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1003;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", 32'(out_valid), 32'd0);
    check("redir_addr", icache_address, 32'h8000_1000);
    tick();
    check("redir_entry", out_pc, 32'h8000_1000);

    // Two redirects during a fill: old line held, newest target wins
    held = icache_address;
    arm_miss(6);
    tick();
    tick();
    check("fill_stall", 32'(icache_stall), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    tick();
    check("pend_flush", 32'(out_valid), 32'd0);
    check("pend_addr1", icache_address, held);
    redirect_pc = 32'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (icache_stall && n < 20) begin
      check("pend_addr_held", icache_address, held);
      tick();
      n++;
    end
    check("pend_fill_done", 32'(icache_stall), 32'd0);
    tick();
    check("pend_drop", 32'(out_valid), 32'd0);
    check("pend_addr_new", icache_address, 32'h8000_3000);
    tick();
    check("pend_entry", out_pc, 32'h8000_3000);

    // Reset in the middle of a fill
    arm_miss(6);
    tick();
    tick();
    check("rf_stall", 32'(icache_stall), 32'd1);
    reset = 1'b1;
    tick();
    check("rf_out_valid", 32'(out_valid), 32'd0);
    check("rf_enable", 32'(icache_enable), 32'd0);
    check("rf_out_pc", out_pc, 32'd0);
    reset = 1'b0;
    check("rf_addr", icache_address, 32'h8000_0000);
    tick();
    check("rf_entry", out_pc, 32'h8000_0000);

    // Wrap past the top of the address space into the uncached region
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap0", out_pc, 32'hFFFF_FFF8);
    tick();
    check("wrap1", out_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap2_pc", out_pc, 32'h0000_0000);
    check("wrap2_instr", out_instr, 32'h0000_0000);

    // Randomized soak: backpressure, redirects (including mid-fill) and misses
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0000;
    tick();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = $urandom & 32'h0000_0FFF;
      else
        redirect_pc = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if (arm_seq == done_seq && !icache_stall && $urandom_range(0, 9) == 0)
        arm_miss(int'($urandom_range(1, 8)));
      tick();
    end
    redirect_valid = 1'b0;
    check("soak_progress", 32'(pops > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
